// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out serializer.
package piso_pkg;

    localparam int unsigned PISO_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } piso_state_e;

endpackage

// File: rtl/piso_cnt.sv
// Bit counter for the serializer: synchronous clear wins over enable.
module piso_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       en_i,
    output logic [$clog2(WIDTH)-1:0]   cnt_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [CW-1:0] cnt_q;

    // Count register: cleared on word accept, advanced once per shifted bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/piso_ser.sv
// Parallel-in/serial-out serializer feeding a downstream 2:1 mux cell.
// ser_s selects the serial bit on D1 only while a word is being shifted.
module piso_ser
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = PISO_WIDTH_DEF,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_d,
    output logic             ser_s,
    output logic             done
);

    localparam int unsigned   CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

    piso_state_e      state_q;
    logic [WIDTH-1:0] sreg_q;
    logic             ser_d_q;
    logic             ser_s_q;
    logic             done_q;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last_bit;
    logic             cnt_en;

    // Bit that leaves the register first for the configured order.
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // One zero-filling shift towards the output end of the register.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign last_bit = (state_q == SHIFT) && (cnt == CntLast);
    // Hold the counter on the last bit so it never wraps inside a word.
    assign cnt_en   = (state_q == SHIFT) && !last_bit;

    piso_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (accept),
        .en_i  (cnt_en),
        .cnt_o (cnt)
    );

    // Control FSM with registered mux outputs; ser_d always mirrors the
    // register's output-end bit while shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            ser_d_q <= 1'b0;
            ser_s_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= SHIFT;
                        sreg_q  <= in_data;
                        ser_s_q <= 1'b1;
                        ser_d_q <= lead_bit(in_data);
                    end
                end
                SHIFT: begin
                    sreg_q <= shift_once(sreg_q);
                    if (last_bit) begin
                        state_q <= DONE;
                        ser_s_q <= 1'b0;
                        ser_d_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        ser_d_q <= lead_bit(shift_once(sreg_q));
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ser_d = ser_d_q;
    assign ser_s = ser_s_q;
    assign done  = done_q;

endmodule

// File: tb/tb_piso_ser.sv
// Bench for piso_ser: three instances (8-bit MSB-first, 8-bit LSB-first,
// 2-bit MSB-first) checked every cycle against a phase-based word model,
// plus literal bit sequences for the directed scenarios.
module tb_piso_ser;

    logic       clk;
    logic       rst_n;
    logic [7:0] din [3];
    logic       vld [3];
    logic       rdy [3];
    logic       sd  [3];
    logic       ss  [3];
    logic       dn  [3];

    int n_chk = 0;
    int n_err = 0;

    piso_ser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(din[0]), .in_valid(vld[0]),
        .in_ready(rdy[0]), .ser_d(sd[0]), .ser_s(ss[0]), .done(dn[0])
    );

    piso_ser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(din[1]), .in_valid(vld[1]),
        .in_ready(rdy[1]), .ser_d(sd[1]), .ser_s(ss[1]), .done(dn[1])
    );

    piso_ser #(.WIDTH(2), .MSB_FIRST(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(din[2][1:0]), .in_valid(vld[2]),
        .in_ready(rdy[2]), .ser_d(sd[2]), .ser_s(ss[2]), .done(dn[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int want);
        n_chk++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    // Word model: phase 0 = idle, 1..W = bit p presented, W+1 = done pulse.
    int         wd   [3] = '{8, 8, 2};
    int         msbf [3] = '{1, 0, 1};
    int         phase[3] = '{0, 0, 0};
    logic [7:0] word [3];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                phase[k] = 0;
            end else if (phase[k] == 0) begin
                if (vld[k]) begin
                    phase[k] = 1;
                    word[k]  = din[k];
                end
            end else if (phase[k] == wd[k] + 1) begin
                phase[k] = 0;
            end else begin
                phase[k] = phase[k] + 1;
            end
        end
    end

    // Per-cycle compare of every instance against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int   p;
            int   e_d;
            p   = phase[k];
            e_d = 0;
            if (p >= 1 && p <= wd[k])
                e_d = (msbf[k] != 0) ? int'(word[k][wd[k] - p]) : int'(word[k][p - 1]);
            chk($sformatf("model_rdy%0d", k), int'(rdy[k]), int'(p == 0));
            chk($sformatf("model_ser_s%0d", k), int'(ss[k]), int'(p >= 1 && p <= wd[k]));
            chk($sformatf("model_ser_d%0d", k), int'(sd[k]), e_d);
            chk($sformatf("model_done%0d", k), int'(dn[k]), int'(p == wd[k] + 1));
        end
    end

    logic [7:0] lit0;
    logic [7:0] lit1;
    logic [1:0] lit2;
    int         ndone;

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            din[k] = 8'h00;
            vld[k] = 1'b0;
        end
        #1;
        chk("rst_rdy", int'(rdy[0]), 1);
        chk("rst_ser_s", int'(ss[0]), 0);
        chk("rst_ser_d", int'(sd[0]), 0);
        chk("rst_done", int'(dn[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 0xA5 MSB-first, 0x01 LSB-first, 2'b10 on the 2-bit instance.
        lit0 = 8'b1010_0101;
        lit1 = 8'b1000_0000;
        lit2 = 2'b10;
        din[0] = 8'hA5; din[1] = 8'h01; din[2] = 8'h02;
        vld[0] = 1'b1;  vld[1] = 1'b1;  vld[2] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                vld[0] = 1'b0; vld[1] = 1'b0; vld[2] = 1'b0;
            end
            if (c <= 8) begin
                chk("a5_ser_s", int'(ss[0]), 1);
                chk("a5_bit", int'(sd[0]), int'(lit0[8 - c]));
                chk("01_bit", int'(sd[1]), int'(lit1[8 - c]));
                chk("a5_done_early", int'(dn[0]), 0);
            end
            if (c <= 2) chk("w2_bit", int'(sd[2]), int'(lit2[2 - c]));
            if (c == 3) chk("w2_done", int'(dn[2]), 1);
            if (c == 4) chk("w2_rdy", int'(rdy[2]), 1);
            if (c == 9) begin
                chk("a5_done", int'(dn[0]), 1);
                chk("01_done", int'(dn[1]), 1);
                chk("a5_rdy_busy", int'(rdy[0]), 0);
            end
            if (c == 10) begin
                chk("a5_rdy_back", int'(rdy[0]), 1);
                chk("a5_done_once", int'(dn[0]), 0);
            end
        end

        // Back-to-back: valid held, 0xFF then 0x00.
        din[0] = 8'hFF; vld[0] = 1'b1;
        ndone = 0;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (c == 1) din[0] = 8'h00;
            if (dn[0]) ndone++;
            if (c == 10) begin
                chk("b2b_rdy10", int'(rdy[0]), 1);
                chk("b2b_gap_s", int'(ss[0]), 0);
            end
            if (c == 11) begin
                chk("b2b_ser_s11", int'(ss[0]), 1);
                chk("b2b_bit11", int'(sd[0]), 0);
                vld[0] = 1'b0;
            end
        end
        chk("b2b_ndone", ndone, 2);

        // 0xC3 in flight while 0x3C is offered on cycles 2-7.
        lit0 = 8'b1100_0011;
        din[0] = 8'hC3; vld[0] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) vld[0] = 1'b0;
            if (c == 2) begin
                vld[0] = 1'b1; din[0] = 8'h3C;
            end
            if (c == 8) vld[0] = 1'b0;
            if (c <= 8) chk("c3_bit", int'(sd[0]), int'(lit0[8 - c]));
            if (c >= 2 && c <= 9) chk("c3_rdy_busy", int'(rdy[0]), 0);
            if (c >= 11) begin
                chk("3c_not_taken_s", int'(ss[0]), 0);
                chk("3c_not_taken_rdy", int'(rdy[0]), 1);
            end
        end

        // Async reset mid-word, then 0x81 straight after release.
        din[0] = 8'hFF; vld[0] = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) vld[0] = 1'b0;
        end
        chk("pre_rst_ser_s", int'(ss[0]), 1);
        chk("pre_rst_ser_d", int'(sd[0]), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_ser_s", int'(ss[0]), 0);
        chk("async_ser_d", int'(sd[0]), 0);
        chk("async_done", int'(dn[0]), 0);
        chk("async_rdy", int'(rdy[0]), 1);
        #1 rst_n = 1'b1;
        lit0 = 8'b1000_0001;
        din[0] = 8'h81; vld[0] = 1'b1;
        ndone = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) vld[0] = 1'b0;
            if (dn[0]) ndone++;
            if (c <= 8) chk("81_bit", int'(sd[0]), int'(lit0[8 - c]));
            if (c == 9) chk("81_done", int'(dn[0]), 1);
        end
        chk("81_ndone", ndone, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/piso_ser.md
PISO_SER -- requirements
Module: piso_ser

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of bits per word; legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is shifted out first, 0 = bit 0 is shifted out first.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_data, input, WIDTH: parallel word to serialize.
REQ-006 SHALL have port in_valid, input, 1: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1: block can accept a word.
REQ-008 SHALL have port ser_d, output, 1: serial data bit; drives the D1 input of the downstream 2:1 mux cell.
REQ-009 SHALL have port ser_s, output, 1: select; drives the mux S input; high only while ser_d carries a valid bit.
REQ-010 SHALL have port done, output, 1: single-cycle pulse after the last bit.

Function
REQ-011 SHALL implement states IDLE, SHIFT and DONE.
REQ-012 Transitions SHALL be: IDLE->SHIFT on in_valid&&in_ready; SHIFT->DONE after WIDTH SHIFT cycles; DONE->IDLE unconditionally.
REQ-013 in_ready SHALL be combinational, equal to (state==IDLE).
REQ-014 On accept, in_data SHALL be captured into a WIDTH-bit shift register and a bit counter SHALL be cleared to 0.
REQ-015 In SHIFT, ser_d SHALL be the register's MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0), and the register SHALL shift by one each cycle, zero-filling.
REQ-016 In SHIFT, ser_s SHALL be 1 and the counter SHALL increment each cycle; the last bit is the one presented with counter==WIDTH-1.
REQ-017 Bit counter width SHALL be $clog2(WIDTH); it SHALL never wrap during a word.
REQ-018 Latency: the first bit SHALL appear on ser_d the cycle after acceptance, and done SHALL be high the cycle after the last bit.
REQ-019 Throughput: one word per WIDTH+2 cycles when in_valid is held high.
REQ-020 In IDLE and DONE, ser_d and ser_s SHALL be 0, so the mux selects D0.
REQ-021 in_valid and in_data changes while in_ready=0 SHALL be ignored and SHALL NOT corrupt the word in flight.
REQ-022 ser_d, ser_s and done SHALL be driven from registers, not combinationally from inputs.

Reset
REQ-023 While rst_n=0, state SHALL be IDLE, the shift register and counter SHALL be 0, and ser_d=0, ser_s=0, done=0, in_ready=1, all immediately and independent of clk.
REQ-024 Reset asserted mid-word SHALL discard the word with no done pulse.
REQ-025 After reset release, the first rising edge with in_valid=1 SHALL accept a word.

Structure
REQ-026 The shared package piso_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the default width constant PISO_WIDTH_DEF=8.
REQ-027 The bit counter SHALL be a sub-module piso_cnt with clear, enable and count outputs, parameterized by WIDTH.
REQ-028 No other hierarchy SHALL be used.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1, in_data=0xA5 accepted at cycle 0 -> ser_d=1,0,1,0,0,1,0,1 with ser_s=1 on cycles 1-8; done=1 on cycle 9 only; in_ready=1 again on cycle 10.
REQ-030 MSB_FIRST=0, in_data=0x01 -> ser_d=1,0,0,0,0,0,0,0 on cycles 1-8; done on cycle 9.
REQ-031 in_valid held high with words 0xFF then 0x00 -> second word accepted at cycle 10; first bit of the second word (0) appears at cycle 11; exactly one done per word.
REQ-032 in_data=0xC3 accepted, then in_valid=1 with 0x3C during cycles 2-7 -> the 0xC3 bit sequence is unaffected and 0x3C is not accepted until IDLE.
REQ-033 rst_n pulsed low mid-cycle at cycle 4 of a word -> ser_s, ser_d and done go to 0 without a clock edge; in_ready=1; no done pulse; the next word 0x81 serializes correctly.
REQ-034 WIDTH=2, in_data=2'b10 -> ser_d=1,0 on cycles 1-2; done on cycle 3.
